uart_rx: RTL and testbench

Asynchronous serial receiver for the UART subsystem; the receive-side counterpart of the UART transmitter. It synchronizes the incoming serial line and validates the start bit. It samples 8 data bits LSB-first, an optional even-parity bit and one stop bit at mid-bit, then presents the received byte with a one-cycle valid strobe. It sits between the board-level RX pin and the byte-level consumer (FIFO or register block).

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, LSB first, one stop bit, optional even parity.
// Latency: pin to rx_s is 2 cycles; valid/frame-error pulse one edge after the mid-stop sample.
// Backpressure: none. The consumer must take o_rx_data while o_rx_data_valid is high.
// Ports: i_rx_clk/i_rx_rst (async, active-high), i_rx_serial (async pin, idle high),
//        o_rx_data (last good byte), o_rx_data_valid (1-cycle strobe),
//        o_rx_parity_err (valid with o_rx_data), o_rx_frame_err (1-cycle strobe), o_rx_busy.
// Build option: define UART_RX_PARITY_EN for an even-parity bit between data and stop;
//        without it the parity state is absent and o_rx_parity_err is tied low.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_rx_clk,
    input  logic       i_rx_rst,
    input  logic       i_rx_serial,
    output logic [7:0] o_rx_data,
    output logic       o_rx_data_valid,
    output logic       o_rx_parity_err,
    output logic       o_rx_frame_err,
    output logic       o_rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

    // Control strobes produced by the next-state logic.
    logic cnt_clr, shift_en, data_ld, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic par_en, perr;
`endif

    // Two-flop synchronizer; resets to the idle (high) level so reset
    // release never looks like a start edge.
    always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_rx_serial;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
        if (i_rx_rst) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        data_ld   = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                // Mid-start check: a line back high here was only a glitch.
                if (cnt == HALF_LAST) begin
                    if (!rx_s) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr   = 1'b1;
                    par_en    = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        data_ld   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here until the line returns high so a long break
                // reports only one frame error.
                if (rx_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit-timing counter, bit index and shift register.
    always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            cnt   <= '0;
            idx   <= 3'd0;
            shift <= 8'h00;
        end else begin
            if (cnt_clr) cnt <= '0;
            else         cnt <= cnt + CW'(1);

            if (state != ST_DATA)            idx <= 3'd0;
            else if (shift_en && idx != 3'd7) idx <= idx + 3'd1;

            if (shift_en) shift <= {rx_s, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit XOR all data bits is 0 on a good frame.
    always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            perr            <= 1'b0;
            o_rx_parity_err <= 1'b0;
        end else begin
            if (par_en)  perr            <= rx_s ^ (^shift);
            if (data_ld) o_rx_parity_err <= perr;
        end
    end
`else
    assign o_rx_parity_err = 1'b0;
`endif

    always_ff @(posedge i_rx_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            o_rx_data       <= 8'h00;
            o_rx_data_valid <= 1'b0;
            o_rx_frame_err  <= 1'b0;
        end else begin
            o_rx_data_valid <= data_ld;
            o_rx_frame_err  <= ferr_set;
            if (data_ld) o_rx_data <= shift;
        end
    end

    assign o_rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives whole UART frames onto the pin and compares the received
// bytes, parity flags and frame errors against a frame-level model.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NBITS   = PAR ? 11 : 10;
    localparam int EXP_LAT = 2 + CPB * (NBITS - 1) + CPB / 2 + 1;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rx_pin = 1'b1;
    logic [7:0] data;
    logic       dv, perr, ferr, busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_rx_clk        (clk),
        .i_rx_rst        (rst),
        .i_rx_serial     (rx_pin),
        .o_rx_data       (data),
        .o_rx_data_valid (dv),
        .o_rx_parity_err (perr),
        .o_rx_frame_err  (ferr),
        .o_rx_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, val_cyc = 0, busy_cyc = 0, dbl = 0;
    int n_ferr = 0, exp_ferr = 0;
    logic       prev_dv = 1'b0, prev_fe = 1'b0;
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] last_exp = 9'h000;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (dv) begin
            obs_q.push_back({perr, data});
            val_cyc = cyc;
        end
        if (ferr) n_ferr++;
        if ((dv && prev_dv) || (ferr && prev_fe)) dbl++;
        if (busy) busy_cyc++;
        prev_dv = dv;
        prev_fe = ferr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rx_pin = b;
        repeat (CPB) tick();
    endtask

    // Sends one frame; records what a correct receiver must report for it.
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (PAR) bit_out((^d) ^ !par_ok);
        bit_out(stop_ok);
        if (stop_ok) begin
            last_exp = {(PAR && !par_ok), d};
            exp_q.push_back(last_exp);
        end else begin
            exp_ferr++;
        end
    endtask

    task automatic drain(input string tag);
        logic [8:0] o, e;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_byte"}, o, e);
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, "_ferr"}, n_ferr, exp_ferr);
        check({tag, "_pulse1"}, dbl, 0);
        check({tag, "_hold"}, {perr, data}, last_exp);
    endtask

    initial begin
        int         t_fall, b0;
        logic [7:0] d;
        bit         pok, sok;

        // Reset and idle line.
        rst = 1'b1;
        rx_pin = 1'b1;
        repeat (3) tick();
        check("rst_data", data, 8'h00);
        check("rst_valid", dv, 1'b0);
        check("rst_perr", perr, 1'b0);
        check("rst_ferr", ferr, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (100) tick();
        check("idle_busy_cycles", busy_cyc, 0);
        check("idle_busy", busy, 1'b0);
        drain("idle");

        // Single good frame with latency measurement.
        t_fall = cyc;
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (4) tick();
        check("latency", val_cyc - t_fall, EXP_LAT);
        drain("a5");

        // Back-to-back: wrong parity, then correct parity.
        send_frame(8'h3C, 1'b0, 1'b1);
        send_frame(8'h01, 1'b1, 1'b1);
        repeat (4) tick();
        drain("b2b");

        // Short low glitch on an idle line.
        b0 = busy_cyc;
        rx_pin = 1'b0;
        repeat (5) tick();
        rx_pin = 1'b1;
        repeat (30) tick();
        check("glitch_busy", ((busy_cyc - b0) >= 1 && (busy_cyc - b0) <= 10), 1);
        check("glitch_idle", busy, 1'b0);
        drain("glitch");

        // Bad stop bit followed by a long break.
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (40 * CPB) tick();
        rx_pin = 1'b1;
        repeat (2 * CPB) tick();
        drain("break");
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (4) tick();
        drain("after_break");

        // Reset in the middle of data bit 4.
        d = 8'h5A;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(d[i]);
        rx_pin = d[4];
        repeat (CPB / 2) tick();
        rst = 1'b1;
        last_exp = 9'h000;
        tick();
        check("midrst_busy", busy, 1'b0);
        rx_pin = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2 * CPB) tick();
        drain("abort");
        send_frame(8'h12, 1'b1, 1'b1);
        repeat (4) tick();
        drain("post_rst");

        // Random frames: data, parity correctness, stop bit and gaps.
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom_range(0, 255));
            pok = ($urandom_range(0, 3) != 0);
            sok = ($urandom_range(0, 5) != 0);
            send_frame(d, pok, sok);
            if (!sok) begin
                repeat ($urandom_range(0, 3) * CPB + $urandom_range(0, 7)) tick();
                rx_pin = 1'b1;
                repeat (CPB) tick();
            end else begin
                repeat ($urandom_range(0, 20)) tick();
            end
            if (k % 6 == 5) begin
                repeat (4) tick();
                drain("rand");
            end
        end
        repeat (4) tick();
        drain("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
